ace_tap_player: RTL and testbench

- Tape-image player for the Jupiter ACE core.
- Captures a .tap image downloaded over the MiST ioctl channel into internal block RAM.
- On command, replays it as a square-wave EAR signal that drives the core's ear input in place of UART_RX.
- Sits between mist_io (upstream) and jupiter_ace (downstream); runs in the clk_65 domain.

---
 rtl/ace_tap_player.sv | 199 +++++++++++++++++++
 tb/tb_ace_tap_player.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_tap_player.sv
// rtl/ace_tap_player.sv - Jupiter ACE .tap image capture into block RAM and EAR square-wave replay.
// Optional feature macro: TAP_PAUSE_EN (adds a pause input that freezes playback).
module ace_tap_player #(
    parameter int ADDR_W      = 14,
    parameter int LEADER_HDR  = 8192,
    parameter int LEADER_DAT  = 1024,
    parameter int LEADER_HALF = 4022,
    parameter int SYNC_HI     = 1202,
    parameter int SYNC_LO     = 1582,
    parameter int BIT0_HALF   = 1602,
    parameter int BIT1_HALF   = 3182,
    parameter int END_HALF    = 2002,
    parameter int GAP         = 6500000
) (
    input  logic              clk,
    input  logic              reset,
`ifdef TAP_PAUSE_EN
    input  logic              pause,
`endif
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    input  logic              play,
    input  logic              stop,
    output logic              ear,
    output logic              busy,
    output logic [7:0]        block_idx
);
    localparam int PW = ADDR_W + 1;

    localparam logic [22:0] T_LEADER = 23'(LEADER_HALF - 1);
    localparam logic [22:0] T_SYNC_H = 23'(SYNC_HI - 1);
    localparam logic [22:0] T_SYNC_L = 23'(SYNC_LO - 2);
    localparam logic [22:0] T_BIT0   = 23'(BIT0_HALF);
    localparam logic [22:0] T_BIT1   = 23'(BIT1_HALF);
    localparam logic [22:0] T_END    = 23'(END_HALF - 1);
    localparam logic [22:0] T_GAP    = 23'(GAP - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_LEADER, S_SYNC_HI, S_SYNC_LO,
        S_FETCH, S_BIT_HI, S_BIT_LO, S_END, S_GAP
    } state_t;

    state_t state, state_n;

    logic [7:0]    ram [2**ADDR_W];
    logic [7:0]    ram_q, sr, len_lo;
    logic [PW-1:0] rd_ptr, rd_ptr_inc, img_len, img_len_n;
    logic [15:0]   remain, leader_cnt, blk_len;
    logic [2:0]    bit_cnt;
    logic [22:0]   cnt, limit, half;
    logic          dl_active_q, kill, hold, start, done, more, at_end;

    // The RAM is read every clock at rd_ptr; rd_ptr is advanced one byte ahead so
    // the next byte is already waiting when FETCH loads it.
    always_ff @(posedge clk) begin
        if (dl_active && dl_wr)
            ram[dl_addr] <= dl_data;
        ram_q <= ram[rd_ptr[ADDR_W-1:0]];
    end

    always_comb begin
        img_len_n = (dl_active && !dl_active_q) ? '0 : img_len;
        if (dl_active && dl_wr && (({1'b0, dl_addr} + PW'(1)) > img_len_n))
            img_len_n = {1'b0, dl_addr} + PW'(1);
    end

`ifdef TAP_PAUSE_EN
    assign hold = pause && busy;
`else
    assign hold = 1'b0;
`endif

    assign kill       = stop || (dl_active && state != S_IDLE);
    assign at_end     = (rd_ptr == img_len);
    assign rd_ptr_inc = at_end ? rd_ptr : rd_ptr + PW'(1);
    assign more       = (remain != 16'd0) && !at_end;
    assign half       = sr[7] ? T_BIT1 : T_BIT0;
    // A block whose header runs into the end of the image is played as empty.
    assign blk_len    = ((rd_ptr + PW'(1)) < img_len) ? {ram_q, len_lo} : 16'd0;

    always_comb begin
        state_n = state;
        start   = 1'b0;
        limit   = '0;
        case (state)
            S_LEN_LO, S_LEN_HI: limit = 23'd1;
            S_LEADER:           limit = T_LEADER;
            S_SYNC_HI:          limit = T_SYNC_H;
            S_SYNC_LO:          limit = T_SYNC_L;
            S_BIT_HI:           limit = half - 23'd1;
            // FETCH supplies the final low clock before the next byte.
            S_BIT_LO:           limit = (bit_cnt == 3'd7 && more) ? half - 23'd2 : half - 23'd1;
            S_END:              limit = T_END;
            S_GAP:              limit = T_GAP;
            default:            limit = '0;
        endcase
        done = (cnt == limit);
        if (kill) begin
            state_n = S_IDLE;
        end else if (!hold) begin
            case (state)
                S_IDLE: if (play && !dl_active && img_len != '0) begin
                    start   = 1'b1;
                    state_n = S_LEN_LO;
                end
                S_LEN_LO:  if (done) state_n = S_LEN_HI;
                S_LEN_HI:  if (done) state_n = (blk_len == 16'd0) ? S_GAP : S_LEADER;
                S_LEADER:  if (done && leader_cnt == 16'd1) state_n = S_SYNC_HI;
                S_SYNC_HI: if (done) state_n = S_SYNC_LO;
                S_SYNC_LO: if (done) state_n = S_FETCH;
                S_FETCH:   state_n = S_BIT_HI;
                S_BIT_HI:  if (done) state_n = S_BIT_LO;
                S_BIT_LO:  if (done) state_n = (bit_cnt != 3'd7) ? S_BIT_HI : (more ? S_FETCH : S_END);
                S_END:     if (done) state_n = S_GAP;
                S_GAP:     if (done) state_n = at_end ? S_IDLE : S_LEN_LO;
                default:   state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            ear         <= 1'b0;
            busy        <= 1'b0;
            block_idx   <= 8'd0;
            rd_ptr      <= '0;
            img_len     <= '0;
            dl_active_q <= 1'b0;
            sr          <= 8'd0;
            len_lo      <= 8'd0;
            remain      <= 16'd0;
            leader_cnt  <= 16'd0;
            bit_cnt     <= 3'd0;
        end else begin
            dl_active_q <= dl_active;
            img_len     <= img_len_n;
            state       <= state_n;
            if (kill) begin
                cnt  <= '0;
                ear  <= 1'b0;
                busy <= 1'b0;
            end else if (!hold) begin
                cnt <= done ? '0 : cnt + 23'd1;
                case (state)
                    S_IDLE: if (start) begin
                        rd_ptr    <= '0;
                        block_idx <= 8'd0;
                        busy      <= 1'b1;
                    end
                    S_LEN_LO: if (done) begin
                        len_lo <= ram_q;
                        rd_ptr <= rd_ptr_inc;
                    end
                    S_LEN_HI: if (done) begin
                        rd_ptr     <= rd_ptr_inc;
                        remain     <= blk_len;
                        leader_cnt <= block_idx[0] ? 16'(LEADER_DAT) : 16'(LEADER_HDR);
                        if (blk_len != 16'd0)
                            ear <= 1'b1;
                    end
                    S_LEADER: if (done) begin
                        leader_cnt <= leader_cnt - 16'd1;
                        ear        <= (leader_cnt == 16'd1) ? 1'b1 : ~ear;
                    end
                    S_SYNC_HI: if (done) ear <= 1'b0;
                    S_FETCH: begin
                        sr      <= ram_q;
                        bit_cnt <= 3'd0;
                        rd_ptr  <= rd_ptr_inc;
                        remain  <= remain - 16'd1;
                        ear     <= 1'b1;
                    end
                    S_BIT_HI: if (done) ear <= 1'b0;
                    S_BIT_LO: if (done) begin
                        if (bit_cnt != 3'd7) begin
                            sr      <= {sr[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                            ear     <= 1'b1;
                        end else if (!more) begin
                            ear <= 1'b1;
                        end
                    end
                    S_END: if (done) ear <= 1'b0;
                    S_GAP: if (done) begin
                        if (block_idx != 8'hFF)
                            block_idx <= block_idx + 8'd1;
                        if (at_end)
                            busy <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ace_tap_player.sv
// tb/tb_ace_tap_player.sv - scoreboard bench for ace_tap_player (EAR run lengths, block index, abort paths).
module tb_ace_tap_player;
    logic        clk = 1'b0;
    logic        reset, dl_active, dl_wr, play, stop, ear, busy;
    logic [13:0] dl_addr;
    logic [7:0]  dl_data, block_idx;
`ifdef TAP_PAUSE_EN
    logic        pause;
`endif

    always #5 clk = ~clk;

    ace_tap_player #(
        .ADDR_W(14), .LEADER_HDR(4), .LEADER_DAT(2), .LEADER_HALF(10),
        .SYNC_HI(6), .SYNC_LO(7), .BIT0_HALF(3), .BIT1_HALF(5),
        .END_HALF(4), .GAP(20)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef TAP_PAUSE_EN
        .pause(pause),
`endif
        .dl_active(dl_active),
        .dl_wr(dl_wr),
        .dl_addr(dl_addr),
        .dl_data(dl_data),
        .play(play),
        .stop(stop),
        .ear(ear),
        .busy(busy),
        .block_idx(block_idx)
    );

    typedef struct {
        logic lvl;
        int   len;
        int   idx;
        bit   chk_idx;
    } seg_t;

    seg_t        exp_q[$];
    logic [7:0]  img[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    bit          in_run = 1'b0;
    logic        cur_lvl;
    int          run_len;
    logic [7:0]  run_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic add_seg(input logic lvl, input int len, input int idx, input bit ci);
        seg_t s;
        if (exp_q.size() > 0 && exp_q[exp_q.size()-1].lvl == lvl) begin
            s = exp_q.pop_back();
            s.len += len;
        end else begin
            s.lvl = lvl; s.len = len; s.idx = idx; s.chk_idx = ci;
        end
        exp_q.push_back(s);
    endtask

    // Expected EAR waveform of one block, as played while busy.
    task automatic push_block(input int idx, input int n, input logic [7:0] b0, input logic [7:0] b1, input int extra);
        logic [7:0] b;
        int h;
        add_seg(1'b0, 4, idx, 1'b0);
        if (n == 0) begin
            add_seg(1'b0, 20, idx, 1'b0);
            return;
        end
        for (int i = 0; i < ((idx % 2 == 1) ? 2 : 4); i++)
            add_seg((i % 2 == 0), 10, idx, (i == 0));
        add_seg(1'b1, 6, idx, 1'b0);
        add_seg(1'b0, 7, idx, 1'b0);
        for (int k = 0; k < n; k++) begin
            b = (k == 0) ? b0 : b1;
            for (int j = 7; j >= 0; j--) begin
                h = b[j] ? 5 : 3;
                add_seg(1'b1, h + ((k == 0 && j == 7) ? extra : 0), idx, 1'b0);
                add_seg(1'b0, h, idx, 1'b0);
            end
        end
        add_seg(1'b1, 4, idx, 1'b0);
        add_seg(1'b0, 20, idx, 1'b0);
    endtask

    task automatic close_run;
        seg_t s;
        chk("seg_avail", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            s = exp_q.pop_front();
            chk("seg_level", cur_lvl, s.lvl);
            chk("seg_length", run_len, s.len);
            if (s.chk_idx)
                chk("leader_block_idx", run_idx, s.idx);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && busy) begin
            if (!in_run) begin
                in_run = 1'b1; cur_lvl = ear; run_len = 1; run_idx = block_idx;
            end else if (ear === cur_lvl) begin
                run_len++;
            end else begin
                close_run();
                cur_lvl = ear; run_len = 1; run_idx = block_idx;
            end
        end else if (in_run) begin
            close_run();
            in_run = 1'b0;
        end
    end

    task automatic download;
        @(posedge clk); #1 dl_active = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < img.size(); i++) begin
            dl_wr = 1'b1; dl_addr = 14'(i); dl_data = img[i];
            @(posedge clk); #1;
        end
        dl_wr = 1'b0; dl_active = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_play;
        @(posedge clk); #1 play = 1'b1;
        @(posedge clk); #1 play = 1'b0;
    endtask

    task automatic wait_busy;
        int n = 0;
        while (!busy && n < 10) begin @(negedge clk); n++; end
        chk("busy_rise", busy, 1);
    endtask

    task automatic run_check(input int exp_idx, input bit repulse);
        int n = 0;
        mon_en = 1'b1;
        pulse_play();
        wait_busy();
        if (repulse) begin
            repeat (30) @(negedge clk);
            pulse_play();
        end
        while (busy && n < 5000) begin @(negedge clk); n++; end
        chk("busy_fall", busy, 0);
        @(negedge clk); @(negedge clk);
        chk("segments_left", exp_q.size(), 0);
        chk("block_idx_end", block_idx, exp_idx);
        mon_en = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        play = 1'b0; stop = 1'b0;
`ifdef TAP_PAUSE_EN
        pause = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_ear", ear, 0);
        chk("reset_busy", busy, 0);
        chk("reset_block_idx", block_idx, 0);

        // Empty image: play must be refused.
        pulse_play();
        repeat (3) @(posedge clk);
        #1 chk("empty_play_busy", busy, 0);

        img = '{8'h01, 8'h00, 8'hA5};
        download();
        push_block(0, 1, 8'hA5, 8'h00, 0);
        run_check(1, 1'b0);

        // Two blocks; a second play mid-run must be ignored.
        img = '{8'h01, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h00};
        download();
        push_block(0, 1, 8'hFF, 8'h00, 0);
        push_block(1, 1, 8'h00, 8'h00, 0);
        run_check(2, 1'b1);

        img = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h80};
        download();
        push_block(0, 0, 8'h00, 8'h00, 0);
        push_block(1, 1, 8'h80, 8'h00, 0);
        run_check(2, 1'b0);

        img = '{8'h05, 8'h00, 8'h11, 8'h22};
        download();
        push_block(0, 2, 8'h11, 8'h22, 0);
        run_check(1, 1'b0);

        // Stop in the middle of the leader.
        img = '{8'h01, 8'h00, 8'hA5};
        download();
        pulse_play();
        wait_busy();
        repeat (10) @(negedge clk);
        chk("leader_ear_high", ear, 1);
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        chk("stop_ear", ear, 0);
        chk("stop_busy", busy, 0);

        // Simultaneous play and stop from IDLE.
        @(posedge clk); #1 play = 1'b1; stop = 1'b1;
        @(posedge clk); #1 play = 1'b0; stop = 1'b0;
        chk("play_stop_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1 chk("play_stop_busy_later", busy, 0);
        chk("play_stop_ear_later", ear, 0);

        // Download starting while a bit is being played.
        pulse_play();
        wait_busy();
        repeat (59) @(negedge clk);
        chk("bit_hi_ear", ear, 1);
        @(posedge clk); #1 dl_active = 1'b1;
        @(posedge clk); #1;
        chk("dl_interrupt_busy", busy, 0);
        chk("dl_interrupt_ear", ear, 0);
        dl_active = 1'b0;

`ifdef TAP_PAUSE_EN
        img = '{8'h01, 8'h00, 8'hA5};
        download();
        push_block(0, 1, 8'hA5, 8'h00, 50);
        mon_en = 1'b1;
        pulse_play();
        wait_busy();
        repeat (58) @(negedge clk);
        @(posedge clk); #1 pause = 1'b1;
        repeat (50) @(posedge clk);
        #1 pause = 1'b0;
        begin
            int n = 0;
            while (busy && n < 5000) begin @(negedge clk); n++; end
            chk("pause_busy_fall", busy, 0);
        end
        @(negedge clk); @(negedge clk);
        chk("pause_segments_left", exp_q.size(), 0);
        mon_en = 1'b0;
        exp_q.delete();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
